// File: rtl/div_norm_pkg.sv
// Shared types, widths and the Q8.8 saturating conversion for div_norm_seq.
package div_norm_pkg;

  localparam int DIV_IN_W  = 32;
  localparam int DIV_OUT_W = 48;
  localparam int FRAC_W    = 16;
  localparam int OUT_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Quotient above 255 cannot be represented in Q8.8, so it clamps to all ones.
  function automatic logic [OUT_W-1:0] sat_q8_8(input logic [DIV_OUT_W-1:0] dout);
    logic [DIV_IN_W-1:0] q;
    q = dout[DIV_OUT_W-1:FRAC_W];
    if (q > 32'd255) begin
      sat_q8_8 = 16'hFFFF;
    end else begin
      sat_q8_8 = {q[7:0], dout[FRAC_W-1:FRAC_W-8]};
    end
  endfunction

endpackage

// File: rtl/div_norm_fifo.sv
// Synchronous result FIFO holding {last, data}; outputs come straight from registers.
module div_norm_fifo
  import div_norm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 17
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/div_norm_seq.sv
// Frame sequencer around the divider core; optional divide-by-zero bypass
// is enabled by defining DIV_NORM_DBZ_CHECK_EN.
module div_norm_seq
  import div_norm_pkg::*;
#(
  parameter int IDIM  = 26,
  parameter int DEPTH = 8
) (
  input  logic                 aclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_IN_W-1:0]  divisor,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIV_IN_W-1:0]  in_data,
  output logic                 div_dvsr_tvalid,
  input  logic                 div_dvsr_tready,
  output logic [DIV_IN_W-1:0]  div_dvsr_tdata,
  output logic                 div_dvnd_tvalid,
  input  logic                 div_dvnd_tready,
  output logic [DIV_IN_W-1:0]  div_dvnd_tdata,
  input  logic                 div_dout_tvalid,
  input  logic [DIV_OUT_W-1:0] div_dout_tdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy
`ifdef DIV_NORM_DBZ_CHECK_EN
  , output logic               dbz_flag
`endif
);

  localparam int CNT_W = $clog2(IDIM + 1);
  localparam int OCW   = $clog2(DEPTH + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_IN_W-1:0] r_divisor;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_pushed;
  logic [OCW-1:0]      r_outstanding;
  logic                w_start;
  logic                w_credit_ok;
  logic                w_dbz;
  logic                w_req;
  logic                w_fire;
  logic                w_push;
  logic [OUT_W-1:0]    w_push_res;
  logic                w_pop;
  logic                w_empty;
  logic [OUT_W:0]      w_fifo_dout;

  assign w_start     = (r_state == IDLE) & start;
  assign w_credit_ok = (r_outstanding < OCW'(DEPTH));
  assign w_req       = (r_state == RUN) & in_valid & w_credit_ok;
  assign w_fire      = w_req & (w_dbz | (div_dvsr_tready & div_dvnd_tready));

  assign in_ready        = w_fire;
  assign div_dvsr_tvalid = w_req & ~w_dbz;
  assign div_dvnd_tvalid = w_req & ~w_dbz;
  assign div_dvsr_tdata  = r_divisor;
  assign div_dvnd_tdata  = in_data;

  assign out_valid = ~w_empty;
  assign out_data  = w_fifo_dout[OUT_W-1:0];
  assign out_last  = w_fifo_dout[OUT_W];
  assign busy      = (r_state != IDLE);
  assign w_pop     = out_valid & out_ready;

`ifdef DIV_NORM_DBZ_CHECK_EN
  logic r_dbz_push;
  logic r_dbz_flag;

  assign w_dbz      = (r_divisor == 32'd0);
  assign w_push     = w_dbz ? r_dbz_push : div_dout_tvalid;
  assign w_push_res = w_dbz ? 16'hFFFF : sat_q8_8(div_dout_tdata);
  assign dbz_flag   = r_dbz_flag;

  // Zero-divisor elements bypass the core and land in the FIFO one cycle after acceptance.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_dbz_push <= 1'b0;
      r_dbz_flag <= 1'b0;
    end else begin
      r_dbz_push <= w_fire & w_dbz;
      if (w_start) begin
        r_dbz_flag <= 1'b0;
      end else if (w_fire & w_dbz) begin
        r_dbz_flag <= 1'b1;
      end
    end
  end
`else
  assign w_dbz      = 1'b0;
  assign w_push     = div_dout_tvalid;
  assign w_push_res = sat_q8_8(div_dout_tdata);
`endif

  div_norm_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W + 1)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_din   ({(r_pushed == CNT_W'(IDIM - 1)), w_push_res}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_fire && (r_issued == CNT_W'(IDIM - 1))) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (w_pop && out_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Divisor latch, frame counters and the in-flight credit counter.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_divisor     <= '0;
      r_issued      <= '0;
      r_pushed      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_start) begin
        r_divisor <= divisor;
        r_issued  <= '0;
        r_pushed  <= '0;
      end else begin
        if (w_fire) begin
          r_issued <= r_issued + CNT_W'(1);
        end
        if (w_push) begin
          r_pushed <= r_pushed + CNT_W'(1);
        end
      end
      case ({w_fire, w_pop})
        2'b10:   r_outstanding <= r_outstanding + OCW'(1);
        2'b01:   r_outstanding <= r_outstanding - OCW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
